// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - registered N:1 channel mux with manual or round-robin select
// Optional RRMUX_XFER_CNT_EN adds a saturating 16-bit output handshake counter (xfer_cnt).
module rr_mux_reg #(
   parameter int  WIDTH = 8,
   parameter int  N     = 4,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_chan
`ifdef RRMUX_XFER_CNT_EN
   ,
   output logic [15:0]          xfer_cnt
`endif
);

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [SELW-1:0]  r_out_chan;
   logic [SELW-1:0]  r_ptr;

   logic             w_load;
   logic             w_man_elig;
   logic             w_rr_elig;
   logic [SELW-1:0]  w_rr_cand;
   logic             w_elig;
   logic [SELW-1:0]  w_cand;
   logic             w_grant;
   logic [N-1:0]     w_in_ready;
   logic [WIDTH-1:0] w_sel_data;
   logic [SELW-1:0]  w_ptr_nxt;

   assign w_load = !r_out_valid || out_ready;

   // Manual select: an out-of-range sel matches no channel and so is never eligible.
   always_comb begin
      w_man_elig = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (sel == SELW'(k)) begin
            w_man_elig = in_valid[k];
         end
      end
   end

   // Round-robin search starting at r_ptr, wrapping modulo N.
   always_comb begin
      int j;
      w_rr_elig = 1'b0;
      w_rr_cand = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(r_ptr) + i;
         if (j >= N) begin
            j = j - N;
         end
         if (!w_rr_elig && in_valid[j]) begin
            w_rr_elig = 1'b1;
            w_rr_cand = SELW'(j);
         end
      end
   end

   assign w_elig  = mode ? w_rr_elig : w_man_elig;
   assign w_cand  = mode ? w_rr_cand : sel;
   assign w_grant = rst_n && w_load && w_elig;

   always_comb begin
      w_in_ready = '0;
      w_sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (w_cand == SELW'(k)) begin
            w_in_ready[k] = w_grant;
            w_sel_data    = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_ptr_nxt = (w_cand == SELW'(N-1)) ? '0 : w_cand + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_chan  <= '0;
         r_ptr       <= '0;
      end else if (w_load) begin
         if (w_grant) begin
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_cand;
            r_out_valid <= 1'b1;
            if (mode) begin
               r_ptr <= w_ptr_nxt;
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef RRMUX_XFER_CNT_EN
   logic [15:0] r_xfer_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_xfer_cnt <= '0;
      end else if (r_out_valid && out_ready && (r_xfer_cnt != 16'hFFFF)) begin
         r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
   end

   assign xfer_cnt = r_xfer_cnt;
`else
`endif

   assign in_ready  = w_in_ready;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - directed self-checking bench for rr_mux_reg (N=4, WIDTH=8)
// Define RRMUX_XFER_CNT_EN to also exercise the xfer_cnt counter.
module tb_rr_mux_reg;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic               clk;
   logic               rst_n;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SELW-1:0]    out_chan;
`ifdef RRMUX_XFER_CNT_EN
   logic [15:0]        xfer_cnt;
`endif

   int errors = 0;
   int checks = 0;

   rr_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan)
`ifdef RRMUX_XFER_CNT_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".chan"},  32'(out_chan),  32'(c));
   endtask

   initial begin
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;

      rst_n     = 1'b0;
      mode      = 1'b1;
      sel       = 2'd0;
      in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
      in_valid  = 4'b1111;
      out_ready = 1'b1;

      // reset held two cycles with all inputs valid
      #1;
      chk("rst.in_ready0", 32'(in_ready), 32'h0);
      tick();
      chk_out("rst1", 1'b0, 8'h00, 2'd0);
      chk("rst.in_ready1", 32'(in_ready), 32'h0);
      tick();
      chk_out("rst2", 1'b0, 8'h00, 2'd0);
      rst_n = 1'b1;
      #1;
      chk("rr.first_grant", 32'(in_ready), 32'b0001);

      // round-robin fairness: 0,1,2,3,0,1
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_out($sformatf("rr.seq%0d", i), 1'b1, exp_d[i % 4], 2'(i % 4));
      end

      // drive ptr to 3 by granting ch2
      in_valid = 4'b0100;
      #1;
      chk("skip.in_ready_ch2", 32'(in_ready), 32'b0100);
      tick();
      chk_out("skip.ch2", 1'b1, 8'h33, 2'd2);
      in_valid = 4'b0010;
      #1;
      chk("skip.in_ready_ch1", 32'(in_ready), 32'b0010);
      tick();
      chk_out("skip.ch1", 1'b1, 8'h22, 2'd1);
      in_valid = 4'b1001;
      #1;
      chk("wrap.in_ready_ch3", 32'(in_ready), 32'b1000);
      tick();
      chk_out("wrap.ch3", 1'b1, 8'h44, 2'd3);
      chk("wrap.in_ready_ch0", 32'(in_ready), 32'b0001);
      tick();
      chk_out("wrap.ch0", 1'b1, 8'h11, 2'd0);

      // manual mode
      mode     = 1'b0;
      sel      = 2'd2;
      in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
      in_valid = 4'b0100;
      #1;
      chk("man.in_ready_sel2", 32'(in_ready), 32'b0100);
      tick();
      chk_out("man.sel2", 1'b1, 8'hA5, 2'd2);
      sel = 2'd1;
      #1;
      chk("man.in_ready_sel1", 32'(in_ready), 32'h0);
      tick();
      chk_out("man.drop", 1'b0, 8'hA5, 2'd2);

      // backpressure
      sel      = 2'd0;
      in_data  = {8'h44, 8'h33, 8'h22, 8'h3C};
      in_valid = 4'b0001;
      tick();
      chk_out("bp.load", 1'b1, 8'h3C, 2'd0);
      out_ready = 1'b0;
      in_data   = {8'h44, 8'h33, 8'h22, 8'h5A};
      in_valid  = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'h0);
         tick();
         chk_out($sformatf("bp.hold%0d", i), 1'b1, 8'h3C, 2'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release_ready", 32'(in_ready), 32'b0001);
      tick();
      chk_out("bp.next", 1'b1, 8'h5A, 2'd0);
      in_valid = 4'b0000;
      tick();
      chk_out("bp.empty", 1'b0, 8'h5A, 2'd0);

      // reset mid-transfer discards held word and resets ptr
      in_valid = 4'b0010;
      sel      = 2'd1;
      tick();
      chk_out("mid.load", 1'b1, 8'h22, 2'd1);
      out_ready = 1'b0;
      rst_n     = 1'b0;
      mode      = 1'b1;
      in_valid  = 4'b1111;
      #1;
      chk("mid.in_ready_rst", 32'(in_ready), 32'h0);
      tick();
      chk_out("mid.rst", 1'b0, 8'h00, 2'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("mid.ptr_reset", 32'(in_ready), 32'b0001);

`ifdef RRMUX_XFER_CNT_EN
      chk("cnt.reset", 32'(xfer_cnt), 32'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
      end
      chk("cnt.five", 32'(xfer_cnt), 32'd5);
      dut.r_xfer_cnt = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      chk("cnt.sat", 32'(xfer_cnt), 32'hFFFF);
      rst_n = 1'b0;
      tick();
      chk("cnt.rst", 32'(xfer_cnt), 32'h0);
      rst_n = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
